// File: rtl/dmem_arbiter.sv
// Two-port (core / loader) data-memory arbiter with a two-state IDLE/ACCESS FSM.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise the core has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [2:0]        c_ctrl,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [2:0]        l_ctrl,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [31:0]       l_wdata,
  output logic              c_gnt,
  output logic              c_rsp,
  output logic              c_err,
  output logic [31:0]       c_rdata,
  output logic              l_gnt,
  output logic              l_rsp,
  output logic              l_err,
  output logic [31:0]       l_rdata,
  output logic              DMWr,
  output logic [2:0]        DMCtrl,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       DataWr,
  input  logic [31:0]       DataRd
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t state_r;
  state_t state_nxt_s;

  logic              start_s;
  logic              done_s;
  logic              pick_l_s;
  logic              legal_s;
  logic              win_l_r;
  logic              we_r;
  logic [2:0]        ctrl_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic              c_gnt_r;
  logic              l_gnt_r;
  logic              c_rsp_r;
  logic              l_rsp_r;
  logic              c_err_r;
  logic              l_err_r;
  logic [31:0]       c_rdata_r;
  logic [31:0]       l_rdata_r;

  function automatic logic ctrl_legal(input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

`ifdef DMEM_ARB_RR_EN
  logic last_l_r;

  // Last-grant tracker; reset value "loader" lets the core win the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_l_r <= 1'b1;
    end else if (start_s) begin
      last_l_r <= pick_l_s;
    end else begin
      last_l_r <= last_l_r;
    end
  end
`endif

  assign start_s = (state_r == ST_IDLE) && (c_req || l_req);
  assign done_s  = (state_r == ST_ACCESS);
  assign legal_s = ctrl_legal(ctrl_r);

  // Winner selection for the current IDLE cycle
  always_comb begin
    pick_l_s = 1'b0;
    if (c_req && l_req) begin
`ifdef DMEM_ARB_RR_EN
      pick_l_s = ~last_l_r;
`else
      pick_l_s = 1'b0;
`endif
    end else if (l_req) begin
      pick_l_s = 1'b1;
    end else begin
      pick_l_s = 1'b0;
    end
  end

  // Next-state logic: every accepted request occupies exactly one ACCESS cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (c_req || l_req) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Transaction capture, grant/response pulses and load data return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_l_r   <= 1'b0;
      we_r      <= 1'b0;
      ctrl_r    <= 3'b010;
      addr_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      c_gnt_r   <= 1'b0;
      l_gnt_r   <= 1'b0;
      c_rsp_r   <= 1'b0;
      l_rsp_r   <= 1'b0;
      c_err_r   <= 1'b0;
      l_err_r   <= 1'b0;
      c_rdata_r <= 32'h0000_0000;
      l_rdata_r <= 32'h0000_0000;
    end else begin
      c_gnt_r <= start_s & ~pick_l_s;
      l_gnt_r <= start_s & pick_l_s;
      c_rsp_r <= done_s & ~win_l_r;
      l_rsp_r <= done_s & win_l_r;
      c_err_r <= done_s & ~win_l_r & ~legal_s;
      l_err_r <= done_s & win_l_r & ~legal_s;
      if (start_s) begin
        win_l_r <= pick_l_s;
        we_r    <= pick_l_s ? l_we    : c_we;
        ctrl_r  <= pick_l_s ? l_ctrl  : c_ctrl;
        addr_r  <= pick_l_s ? l_addr  : c_addr;
        wdata_r <= pick_l_s ? l_wdata : c_wdata;
      end else begin
        win_l_r <= win_l_r;
        we_r    <= we_r;
        ctrl_r  <= ctrl_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      // Only the winner's load updates its rdata; illegal loads return zero
      if (done_s && !we_r) begin
        if (win_l_r) begin
          l_rdata_r <= legal_s ? DataRd : 32'h0000_0000;
        end else begin
          c_rdata_r <= legal_s ? DataRd : 32'h0000_0000;
        end
      end else begin
        c_rdata_r <= c_rdata_r;
        l_rdata_r <= l_rdata_r;
      end
    end
  end

  assign DMWr    = done_s & we_r & legal_s & rst_n;
  assign DMCtrl  = ctrl_r;
  assign addr    = addr_r;
  assign DataWr  = wdata_r;
  assign c_gnt   = c_gnt_r;
  assign l_gnt   = l_gnt_r;
  assign c_rsp   = c_rsp_r;
  assign l_rsp   = l_rsp_r;
  assign c_err   = c_err_r;
  assign l_err   = l_err_r;
  assign c_rdata = c_rdata_r;
  assign l_rdata = l_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small byte-addressable memory model.
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;

  logic              clk;
  logic              rst_n;
  logic              c_req, c_we, l_req, l_we;
  logic [2:0]        c_ctrl, l_ctrl;
  logic [ADDR_W-1:0] c_addr, l_addr;
  logic [31:0]       c_wdata, l_wdata;
  logic              c_gnt, c_rsp, c_err, l_gnt, l_rsp, l_err;
  logic [31:0]       c_rdata, l_rdata;
  logic              DMWr;
  logic [2:0]        DMCtrl;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       DataWr;
  logic [31:0]       DataRd;

  logic [31:0] mem [0:63];
  logic [31:0] word_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_l;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_ctrl(c_ctrl), .c_addr(c_addr), .c_wdata(c_wdata),
    .l_req(l_req), .l_we(l_we), .l_ctrl(l_ctrl), .l_addr(l_addr), .l_wdata(l_wdata),
    .c_gnt(c_gnt), .c_rsp(c_rsp), .c_err(c_err), .c_rdata(c_rdata),
    .l_gnt(l_gnt), .l_rsp(l_rsp), .l_err(l_err), .l_rdata(l_rdata),
    .DMWr(DMWr), .DMCtrl(DMCtrl), .addr(addr), .DataWr(DataWr), .DataRd(DataRd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational memory read, size/extension selected by DMCtrl
  always_comb begin
    word_s = mem[addr[7:2]];
    byte_s = word_s[8*addr[1:0] +: 8];
    half_s = word_s[16*addr[1] +: 16];
    case (DMCtrl)
      3'b000:  DataRd = {{24{byte_s[7]}}, byte_s};
      3'b001:  DataRd = {{16{half_s[15]}}, half_s};
      3'b100:  DataRd = {24'h000000, byte_s};
      3'b101:  DataRd = {16'h0000, half_s};
      default: DataRd = word_s;
    endcase
  end

  // Memory write on the clock edge while DMWr is high
  always @(posedge clk) begin
    if (DMWr) begin
      case (DMCtrl)
        3'b000, 3'b100: mem[addr[7:2]][8*addr[1:0] +: 8] <= DataWr[7:0];
        3'b001, 3'b101: mem[addr[7:2]][16*addr[1] +: 16] <= DataWr[15:0];
        default:        mem[addr[7:2]] <= DataWr;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_c(input logic req, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] a, input logic [31:0] d);
    c_req = req; c_we = we; c_ctrl = ctrl; c_addr = a; c_wdata = d;
  endtask

  task automatic set_l(input logic req, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] a, input logic [31:0] d);
    l_req = req; l_we = we; l_ctrl = ctrl; l_addr = a; l_wdata = d;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    {30'd0, c_gnt, l_gnt}, 32'h0);
    check({tag, "_rsp"},    {30'd0, c_rsp, l_rsp}, 32'h0);
    check({tag, "_err"},    {30'd0, c_err, l_err}, 32'h0);
    check({tag, "_crdata"}, c_rdata, 32'h0);
    check({tag, "_lrdata"}, l_rdata, 32'h0);
    check({tag, "_dmctrl"}, {29'd0, DMCtrl}, 32'h2);
    check({tag, "_addr"},   addr, 32'h0);
    check({tag, "_datawr"}, DataWr, 32'h0);
    check({tag, "_dmwr"},   {31'd0, DMWr}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
    mem[12] = 32'h0000_00F5;  // 0x30
    mem[8]  = 32'h1234_5678;  // 0x20
    rst_n = 1'b0;
    set_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    set_l(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick; tick;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick;

    // Core store W then core load W at 0x10
    set_c(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    tick;
    check("st_cgnt", {31'd0, c_gnt}, 32'h1);
    check("st_lgnt", {31'd0, l_gnt}, 32'h0);
    check("st_dmwr", {31'd0, DMWr}, 32'h1);
    check("st_addr", addr, 32'h10);
    check("st_datawr", DataWr, 32'hDEAD_BEEF);
    set_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick;
    check("st_crsp", {31'd0, c_rsp}, 32'h1);
    check("st_cerr", {31'd0, c_err}, 32'h0);
    check("st_dmwr_off", {31'd0, DMWr}, 32'h0);
    check("st_mem", mem[4], 32'hDEAD_BEEF);
    check("st_rdata_hold", c_rdata, 32'h0);
    set_c(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    tick;
    check("ld_cgnt", {31'd0, c_gnt}, 32'h1);
    check("ld_dmwr", {31'd0, DMWr}, 32'h0);
    set_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick;
    check("ld_crsp", {31'd0, c_rsp}, 32'h1);
    check("ld_crdata", c_rdata, 32'hDEAD_BEEF);
    check("ld_cerr", {31'd0, c_err}, 32'h0);
    check("ld_lrsp", {31'd0, l_rsp}, 32'h0);
    tick;

    // Loader load BU at 0x30 with core idle
    set_l(1'b1, 1'b0, 3'b100, 32'h30, 32'h0);
    tick;
    check("bu_lgnt", {31'd0, l_gnt}, 32'h1);
    check("bu_cgnt", {31'd0, c_gnt}, 32'h0);
    check("bu_dmctrl", {29'd0, DMCtrl}, 32'h4);
    set_l(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick;
    check("bu_lrsp", {31'd0, l_rsp}, 32'h1);
    check("bu_lrdata", l_rdata, 32'h0000_00F5);
    check("bu_crsp", {31'd0, c_rsp}, 32'h0);
    check("bu_crdata", c_rdata, 32'hDEAD_BEEF);
    tick;

    // Loader load with illegal ctrl 011 at 0x20
    set_l(1'b1, 1'b0, 3'b011, 32'h20, 32'h0);
    tick;
    check("ill_lgnt", {31'd0, l_gnt}, 32'h1);
    check("ill_dmwr", {31'd0, DMWr}, 32'h0);
    set_l(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick;
    check("ill_lrsp", {31'd0, l_rsp}, 32'h1);
    check("ill_lerr", {31'd0, l_err}, 32'h1);
    check("ill_lrdata", l_rdata, 32'h0);
    tick;

    // Loader store with illegal ctrl 111 must not write memory
    set_l(1'b1, 1'b1, 3'b111, 32'h20, 32'hAAAA_AAAA);
    tick;
    check("ills_dmwr", {31'd0, DMWr}, 32'h0);
    set_l(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick;
    check("ills_lerr", {31'd0, l_err}, 32'h1);
    check("ills_mem", mem[8], 32'h1234_5678);
    tick;

    // Reset during a pending core store
    set_c(1'b1, 1'b1, 3'b010, 32'h40, 32'h55AA_55AA);
    tick;
    check("rab_cgnt", {31'd0, c_gnt}, 32'h1);
    set_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("rab_dmwr", {31'd0, DMWr}, 32'h0);
    tick;
    check_reset_outputs("rab");
    check("rab_mem", mem[16], 32'h0);
    rst_n = 1'b1;
    tick;
    check("rab_norsp", {31'd0, c_rsp}, 32'h0);

    // Simultaneous held requests from both ports
    set_c(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    set_l(1'b1, 1'b0, 3'b100, 32'h30, 32'h0);
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
      exp_l = (i % 2) == 1;
`else
      exp_l = 1'b0;
`endif
      tick;
      check($sformatf("tie%0d_cgnt", i), {31'd0, c_gnt}, {31'd0, ~exp_l});
      check($sformatf("tie%0d_lgnt", i), {31'd0, l_gnt}, {31'd0, exp_l});
      tick;
      check($sformatf("tie%0d_crsp", i), {31'd0, c_rsp}, {31'd0, ~exp_l});
      check($sformatf("tie%0d_lrsp", i), {31'd0, l_rsp}, {31'd0, exp_l});
    end
    check("tie_crdata", c_rdata, 32'hDEAD_BEEF);
`ifdef DMEM_ARB_RR_EN
    check("tie_lrdata", l_rdata, 32'h0000_00F5);
`else
    check("tie_lrdata", l_rdata, 32'h0);
`endif
    set_c(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    set_l(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    tick; tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
